// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for the 50->75 MHz XGA pixel-clock PLL, clocked by the 50 MHz refclk.
// Optional `PLL_SEQ_STATUS_EN adds an 8-bit saturating lock_loss_cnt status output.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt
`ifdef PLL_SEQ_STATUS_EN
   ,
   output logic [7:0] lock_loss_cnt
`endif
);

   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sync_q, sync_d;
   logic [1:0]         retry_q, retry_d;
   logic               pll_rst_q, pll_rst_d;
   logic               ready_q, ready_d;
   logic               fault_q, fault_d;
   logic               lock_s;
`ifdef PLL_SEQ_STATUS_EN
   logic [7:0]         loss_q, loss_d;
`endif

   assign lock_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      sync_d  = {sync_q[0], pll_locked};
`ifdef PLL_SEQ_STATUS_EN
      loss_d  = loss_q;
`endif
      case (state_q)
         RESET_PLL: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (int'(retry_q) == MAX_RETRIES) begin
                  state_d = FAULT;
               end else begin
                  state_d = RESET_PLL;
                  if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
               end
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               retry_d = 2'd0;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = RESET_PLL;
`ifdef PLL_SEQ_STATUS_EN
               if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
`endif
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = RESET_PLL;
      endcase

      // restart beats any transition above, including a lock-loss count
      if (restart) begin
         state_d = RESET_PLL;
         retry_d = 2'd0;
`ifdef PLL_SEQ_STATUS_EN
         loss_d  = loss_q;
`endif
      end

      // cnt restarts on every state change and saturates in the long-lived states
      if (restart || (state_d != state_q)) cnt_d = '0;
      else if (cnt_q != CNT_W'(CNT_MAX))  cnt_d = cnt_q + 1'b1;
      else                                cnt_d = cnt_q;

      pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= RESET_PLL;
         cnt_q     <= '0;
         sync_q    <= 2'b00;
         retry_q   <= 2'd0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
`ifdef PLL_SEQ_STATUS_EN
         loss_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync_q    <= sync_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
`ifdef PLL_SEQ_STATUS_EN
         loss_q    <= loss_d;
`endif
      end
   end

   assign pll_rst   = pll_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
`ifdef PLL_SEQ_STATUS_EN
   assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: expected waveforms come from event-time arithmetic
// (sync latency, reset/timeout/stable intervals) applied to randomized lock timing.
module tb_pll_lock_sequencer;

   localparam int R  = 4;    // RST_CYCLES
   localparam int T  = 20;   // LOCK_TIMEOUT
   localparam int S  = 8;    // STABLE_CYCLES
   localparam int M  = 2;    // MAX_RETRIES
   localparam int E1 = R + T; // edge at which an unanswered attempt gives up

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, ready, fault;
   logic [1:0] retry_cnt;
`ifdef PLL_SEQ_STATUS_EN
   logic [7:0] lock_loss_cnt;
   int         exp_loss = 0;
`endif

   int checks = 0;
   int failures = 0;

   pll_lock_sequencer #(
      .RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .MAX_RETRIES(M)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
      .pll_rst(pll_rst), .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
`ifdef PLL_SEQ_STATUS_EN
      , .lock_loss_cnt(lock_loss_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Edge (relative to reset release) at which lock is first seen in WAIT_LOCK.
   function automatic int stab_entry(input int d);
      int s1;
      s1 = imax(d + 2, R) + 1;
      if (s1 <= E1) return s1;
      return imax(d + 2, E1 + R) + 1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      restart = 1'b0;
      step();
      step();
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_ready", ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_retry", retry_cnt, 0);
`ifdef PLL_SEQ_STATUS_EN
      exp_loss = 0;
      chk("rst_loss", lock_loss_cnt, 0);
`endif
      rst = 1'b0;
   endtask

   // Starts from a fresh RESET_PLL (cnt=0, lock_s=0). pll_locked rises after edge d;
   // optional glitch drops it for gl cycles starting at STABILIZE count gc.
   task automatic boot_check(input int d, input int gc, input int gl, input int limit);
      int  s, rdy, k_end;
      bit  second;
      second = (imax(d + 2, R) + 1) > E1;
      s      = stab_entry(d);
      rdy    = (gl > 0) ? s + gc + gl + 3 + S : s + S;
      k_end  = (limit > 0) ? limit : rdy + 3;
      for (int k = 1; k <= k_end; k++) begin
         pll_locked = (k >= d + 1) && !(gl > 0 && k >= s + gc + 1 && k <= s + gc + gl);
         step();
         chk("boot_pll_rst", pll_rst, (k < R) || (second && k >= E1 && k < E1 + R));
         chk("boot_ready", ready, k >= rdy);
         chk("boot_fault", fault, 0);
         chk("boot_retry", retry_cnt, (second && k >= E1 && k < rdy) ? 1 : 0);
      end
   endtask

   task automatic lock_loss_check(input int d);
      pll_locked = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("loss_ready", ready, k < 3);
         chk("loss_pll_rst", pll_rst, k >= 3);
         chk("loss_retry", retry_cnt, 0);
      end
`ifdef PLL_SEQ_STATUS_EN
      exp_loss++;
      chk("loss_cnt", lock_loss_cnt, exp_loss);
`endif
      boot_check(d, 0, 0, 0);
   endtask

   task automatic fault_check();
      int fe;
      fe = (M + 1) * E1;
      pll_locked = 1'b0;
      for (int k = 1; k <= fe + 20; k++) begin
         step();
         chk("to_pll_rst", pll_rst, (k >= fe) || ((k % E1) < R));
         chk("to_fault", fault, k >= fe);
         chk("to_retry", retry_cnt, (k >= fe) ? M : k / E1);
         chk("to_ready", ready, 0);
      end
   endtask

   task automatic restart_check(input int h, input int d);
      restart = 1'b1;
      for (int k = 1; k <= h; k++) begin
         step();
         chk("rs_fault", fault, 0);
         chk("rs_pll_rst", pll_rst, 1);
         chk("rs_retry", retry_cnt, 0);
         chk("rs_ready", ready, 0);
      end
      restart = 1'b0;
      boot_check(d, 0, 0, 0);
   endtask

   initial begin
      do_reset();
      // clean start, then lock loss and recovery
      boot_check(10, 0, 0, 0);
      lock_loss_check($urandom_range(0, 12));

      // glitch at STABILIZE count 5 lasting 3 cycles
      do_reset();
      boot_check(0, 5, 3, 0);

      // lock arriving on the last timeout cycle vs one cycle too late
      do_reset();
      boot_check(21, 0, 0, 0);
      do_reset();
      boot_check(22, 0, 0, 0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         boot_check($urandom_range(0, 40), $urandom_range(0, S - 3), $urandom_range(0, 3), 0);
         if (i % 2 == 0) lock_loss_check($urandom_range(0, 30));
      end

      // exhaust retries, then recover via restart
      do_reset();
      fault_check();
      restart_check($urandom_range(1, 3), $urandom_range(0, 20));
      lock_loss_check($urandom_range(0, 12));

      // asynchronous reset between edges, mid-STABILIZE and mid-RUN
      do_reset();
      boot_check(0, 0, 0, stab_entry(0) + 3);
      #3 rst = 1'b1;
      #1;
      chk("async_stab_pll_rst", pll_rst, 1);
      chk("async_stab_ready", ready, 0);
      chk("async_stab_fault", fault, 0);
      do_reset();
      boot_check(3, 0, 0, 0);
      #3 rst = 1'b1;
      #1;
      chk("async_run_pll_rst", pll_rst, 1);
      chk("async_run_ready", ready, 0);
      chk("async_run_retry", retry_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
